// File: rtl/accum_tile_sequencer.sv
// Accumulator bank sequencer: K partial-sum bursts per tile, then drain.
// Optional ACC_SEQ_PERF_EN adds saturating busy/stall counters.
module accum_tile_sequencer #(
  parameter int SYS_COLS    = 4,
  parameter int CNT_W       = 16,
  parameter int DRAIN_EXTRA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_rows,
  input  logic [CNT_W-1:0] cfg_k_tiles,
  input  logic             psum_avail,
  output logic             psum_pop,
  output logic             acc_enable,
  output logic             acc_start,
  output logic             acc_last,
  input  logic             acc_done,
  output logic             tile_done,
  output logic             busy,
  output logic             err
`ifdef ACC_SEQ_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_busy_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int DRAIN_LEN = SYS_COLS + DRAIN_EXTRA;
  localparam int DW = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AVAIL,
    BURST,
    WAIT_DONE,
    DRAIN,
    FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rows_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] k_idx;
  logic [CNT_W-1:0] row_cnt;
  logic [DW-1:0]    drain_cnt;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rows_q     <= '0;
      k_q        <= '0;
      k_idx      <= '0;
      row_cnt    <= '0;
      drain_cnt  <= '0;
      psum_pop   <= 1'b0;
      acc_enable <= 1'b0;
      acc_start  <= 1'b0;
      acc_last   <= 1'b0;
      tile_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            rows_q <= (cfg_rows == '0) ?
                      CNT_W'(1) : cfg_rows;
            k_q    <= (cfg_k_tiles == '0) ?
                      CNT_W'(1) : cfg_k_tiles;
            k_idx  <= '0;
            err    <= 1'b0;
            state  <= WAIT_AVAIL;
          end
        end
        WAIT_AVAIL: begin
          if (psum_avail) begin
            psum_pop   <= 1'b1;
            acc_enable <= 1'b1;
            acc_start  <= (k_idx == '0);
            acc_last   <= (k_idx == k_q - 1'b1);
            row_cnt    <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          psum_pop <= 1'b0;
          if (row_cnt == rows_q - 1'b1) begin
            acc_enable <= 1'b0;
            acc_start  <= 1'b0;
            acc_last   <= 1'b0;
            row_cnt    <= '0;
            state      <= WAIT_DONE;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (acc_done) begin
            if (k_idx < k_q - 1'b1) begin
              k_idx <= k_idx + 1'b1;
              state <= WAIT_AVAIL;
            end else begin
              drain_cnt <= DW'(DRAIN_LEN);
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // drain_cnt cycles spent here before the FINISH pulse
          if (drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt <= DW'(1)) begin
            tile_done <= 1'b1;
            state     <= FINISH;
          end
        end
        FINISH: begin
          tile_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (acc_done && state != WAIT_DONE)
        err <= 1'b1;
    end
  end

`ifdef ACC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (busy && !(&perf_busy_cnt))
        perf_busy_cnt <= perf_busy_cnt + 1'b1;
      if (state == WAIT_AVAIL && !psum_avail &&
          !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_accum_tile_sequencer.sv
// Directed bench for accum_tile_sequencer.
// Bursts are scoreboarded against expected records.
module tb_accum_tile_sequencer;

  typedef struct {
    int len;
    int pops;
    bit start;
    bit last;
    bit cst;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_rows = '0;
  logic [15:0] cfg_k_tiles = '0;
  logic        psum_avail = 1'b0;
  logic        psum_pop;
  logic        acc_enable;
  logic        acc_start;
  logic        acc_last;
  logic        acc_done;
  logic        tile_done;
  logic        busy;
  logic        err;
  logic        auto_done = 1'b0;
  logic        inj_done = 1'b0;
`ifdef ACC_SEQ_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_busy_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;
  int tile_cyc = 0;
  int tile_cnt = 0;
  int t0;

  burst_t exp_q[$];
  burst_t obs_q[$];
  burst_t cur;
  bit     in_burst = 1'b0;
  bit     prev_en = 1'b0;

  assign acc_done = auto_done | inj_done;

  accum_tile_sequencer #(
    .SYS_COLS(4),
    .CNT_W(16),
    .DRAIN_EXTRA(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_rows(cfg_rows),
    .cfg_k_tiles(cfg_k_tiles),
    .psum_avail(psum_avail),
    .psum_pop(psum_pop),
    .acc_enable(acc_enable),
    .acc_start(acc_start),
    .acc_last(acc_last),
    .acc_done(acc_done),
    .tile_done(tile_done),
    .busy(busy),
    .err(err)
`ifdef ACC_SEQ_PERF_EN
    ,
    .perf_clr(perf_clr),
    .perf_busy_cnt(perf_busy_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // bank model + burst monitor
  always @(negedge clk) begin
    if (!rst) begin
      in_burst = 1'b0;
      prev_en = 1'b0;
      auto_done = 1'b0;
    end else begin
      auto_done = prev_en && !acc_enable;
      if (auto_done) done_cyc = cyc;
      prev_en = acc_enable;
      if (acc_enable) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          cur.len = 0;
          cur.pops = 0;
          cur.start = acc_start;
          cur.last = acc_last;
          cur.cst = 1'b1;
        end
        cur.len++;
        if (psum_pop) cur.pops++;
        if (acc_start !== cur.start ||
            acc_last !== cur.last)
          cur.cst = 1'b0;
      end else if (in_burst) begin
        in_burst = 1'b0;
        obs_q.push_back(cur);
      end
      if (tile_done) begin
        tile_cnt++;
        tile_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int len,
                          input bit s,
                          input bit l);
    burst_t b;
    b.len = len;
    b.pops = 1;
    b.start = s;
    b.last = l;
    b.cst = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic cmp_bursts(input string tag);
    burst_t e;
    burst_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, "_missing"}, 32'(obs_q.size()), 32'd1);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_len"}, o.len, e.len);
        chk({tag, "_pops"}, o.pops, e.pops);
        chk({tag, "_start"}, 32'(o.start), 32'(e.start));
        chk({tag, "_last"}, 32'(o.last), 32'(e.last));
        chk({tag, "_const"}, 32'(o.cst), 32'(e.cst));
      end
    end
    chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
  endtask

  task automatic wait_tile(input int target,
                           input string tag);
    int n = 0;
    while (tile_cnt < target && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    assert (tile_cnt >= target) else begin
      fails++;
      $error("FAIL %s_timeout: tiles %0d expected %0d",
             tag, tile_cnt, target);
    end
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!acc_enable && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    assert (acc_enable === 1'b1) else begin
      fails++;
      $error("FAIL %s_en_timeout: observed %b expected 1",
             tag, acc_enable);
    end
  endtask

  task automatic do_cfg(input logic [15:0] r,
                        input logic [15:0] k,
                        input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_rows = r;
    cfg_k_tiles = k;
    @(negedge clk);
    #1;
    cfg_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs",
        32'({acc_enable, acc_start, acc_last,
             psum_pop, tile_done, err}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // rows=4, k=3
    psum_avail = 1'b1;
    push_exp(4, 1'b1, 1'b0);
    push_exp(4, 1'b0, 1'b0);
    push_exp(4, 1'b0, 1'b1);
    t0 = tile_cnt;
    do_cfg(16'd4, 16'd3, "k3");
    wait_tile(t0 + 1, "k3");
    chk("k3_drain_lat", tile_cyc - done_cyc, 6);
    chk("k3_err", 32'(err), 32'd0);
    cmp_bursts("k3");

    // zero fields behave as 1
    push_exp(1, 1'b1, 1'b1);
    t0 = tile_cnt;
    do_cfg(16'd0, 16'd0, "zero");
    wait_tile(t0 + 1, "zero");
    repeat (10) @(negedge clk);
    #1;
    chk("zero_tiles", tile_cnt, t0 + 1);
    cmp_bursts("zero");

    // stall in WAIT_AVAIL
    psum_avail = 1'b0;
`ifdef ACC_SEQ_PERF_EN
    @(negedge clk);
    #1;
    perf_clr = 1'b1;
    @(negedge clk);
    #1;
    perf_clr = 1'b0;
`endif
    push_exp(1, 1'b1, 1'b1);
    t0 = tile_cnt;
    do_cfg(16'd1, 16'd1, "stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_idle",
          32'({acc_enable, psum_pop, cfg_ready}), 32'd0);
    end
    psum_avail = 1'b1;
    wait_tile(t0 + 1, "stall");
`ifdef ACC_SEQ_PERF_EN
    chk("stall_perf", perf_stall_cnt, 32'd10);
`endif
    cmp_bursts("stall");

    // protocol errors
    @(negedge clk);
    #1;
    inj_done = 1'b1;
    @(negedge clk);
    #1;
    inj_done = 1'b0;
    chk("err_idle", 32'(err), 32'd1);
    push_exp(3, 1'b1, 1'b0);
    push_exp(3, 1'b0, 1'b1);
    t0 = tile_cnt;
    do_cfg(16'd3, 16'd2, "err");
    chk("err_clr", 32'(err), 32'd0);
    wait_en("err");
    inj_done = 1'b1;
    @(negedge clk);
    #1;
    inj_done = 1'b0;
    chk("err_burst", 32'(err), 32'd1);
    wait_tile(t0 + 1, "err");
    chk("err_sticky", 32'(err), 32'd1);
    cmp_bursts("err");

    // reset mid-burst
    t0 = tile_cnt;
    do_cfg(16'd6, 16'd1, "rst");
    chk("rst_err_clr", 32'(err), 32'd0);
    wait_en("rst");
    @(negedge clk);
    #2;
    chk("rst_mid_en", 32'(acc_enable), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_outs",
        32'({acc_enable, acc_start, acc_last,
             psum_pop, tile_done, busy}), 32'd0);
    chk("rst_async_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    psum_avail = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_no_tile", tile_cnt, t0);
    chk("rst_ready_after", 32'(cfg_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_no_burst", 32'(obs_q.size()), 32'd0);

    // back-to-back with cfg_valid held
    psum_avail = 1'b1;
    push_exp(2, 1'b1, 1'b1);
    push_exp(2, 1'b1, 1'b1);
    t0 = tile_cnt;
    @(negedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_rows = 16'd2;
    cfg_k_tiles = 16'd1;
    @(negedge clk);
    #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_not_ready", 32'(cfg_ready), 32'd0);
    wait_tile(t0 + 1, "b2b1");
    @(negedge clk);
    #1;
    chk("b2b_idle_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_accept", 32'(busy), 32'd1);
    cfg_valid = 1'b0;
    wait_tile(t0 + 2, "b2b2");
    repeat (20) @(negedge clk);
    #1;
    chk("b2b_tiles", tile_cnt, t0 + 2);
    cmp_bursts("b2b");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
